// File: rtl/ff_delay_line.sv
// ff_delay_line: multi-bit delay line with per-stage valid and runtime tap.
// A delay change drains in-flight words before the new tap takes effect.
module ff_delay_line #(
    parameter int Width      = 8,
    parameter int MaxDepth   = 16,
    parameter int ResetDelay = 4,
    localparam int DW        = $clog2(MaxDepth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic [Width-1:0] d_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [Width-1:0] q_o,
    output logic             valid_o,
    input  logic [DW-1:0]    delay_i,
    input  logic             delay_ld_i,
    output logic [DW-1:0]    delay_o,
    output logic             busy_o,
    output logic             cfg_err_o
);

    typedef enum logic {
        RUN,
        DRAIN
    } state_t;

    state_t              state;
    logic [Width-1:0]    mem [MaxDepth];
    logic [MaxDepth-1:0] vld;
    logic [DW-1:0]       occ;
    logic [DW-1:0]       delay_q;
    logic [DW-1:0]       pend_q;
    logic                cfg_err;

    logic                accept;
    logic                over;
    logic                drain_done;
    logic [Width-1:0]    tap_q;
    logic                tap_v;

    assign ready_o    = (state == RUN);
    assign busy_o     = (state == DRAIN);
    assign accept     = valid_i & ready_o;
    assign over       = (delay_i > DW'(MaxDepth));
    assign drain_done = (state == DRAIN) && (occ == '0);

    assign q_o       = tap_q;
    assign valid_o   = tap_v;
    assign delay_o   = delay_q;
    assign cfg_err_o = cfg_err;

    // Tap mux: depth 0 bypasses the chain, otherwise pick stage delay_q-1
    always_comb begin
        tap_q = d_i;
        tap_v = accept;
        for (int k = 0; k < MaxDepth; k++) begin
            if (delay_q == DW'(k + 1)) begin
                tap_q = mem[k];
                tap_v = vld[k];
            end
        end
    end

    // Data stages shift whenever enabled, independent of valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < MaxDepth; k++) begin
                mem[k] <= '0;
            end
        end else if (en_i) begin
            mem[0] <= d_i;
            for (int k = 1; k < MaxDepth; k++) begin
                mem[k] <= mem[k-1];
            end
        end
    end

    // Valid chain and occupancy; flush and retap both clear in-flight words
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= '0;
            occ <= '0;
        end else if (flush_i || drain_done) begin
            vld <= '0;
            occ <= '0;
        end else if (en_i) begin
            vld <= (vld << 1) | MaxDepth'(accept);
            occ <= occ + DW'(accept) - DW'(tap_v);
        end
    end

    // Delay-change FSM: capture clamped request, wait for empty, retap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RUN;
            delay_q <= DW'(ResetDelay);
            pend_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                RUN: begin
                    if (delay_ld_i) begin
                        pend_q  <= over ? DW'(MaxDepth) : delay_i;
                        cfg_err <= over;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (occ == '0) begin
                        delay_q <= pend_q;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ff_delay_line.sv
// tb_ff_delay_line: directed checks of latency, stall, retap, flush,
// clamp and reset behaviour of ff_delay_line at its default parameters.
module tb_ff_delay_line;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] d = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] q;
    logic       valid_out;
    logic [4:0] dly = '0;
    logic       ld = 1'b0;
    logic [4:0] delay_out;
    logic       busy;
    logic       cfg_err;

    int total = 0;
    int bad = 0;

    ff_delay_line dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .flush_i   (flush),
        .d_i       (d),
        .valid_i   (valid),
        .ready_o   (ready),
        .q_o       (q),
        .valid_o   (valid_out),
        .delay_i   (dly),
        .delay_ld_i(ld),
        .delay_o   (delay_out),
        .busy_o    (busy),
        .cfg_err_o (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a new cycle just after the edge with all inputs at defaults
    task automatic tick();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        en    = 1'b1;
        flush = 1'b0;
        valid = 1'b0;
        d     = '0;
        ld    = 1'b0;
        dly   = '0;
    endtask

    initial begin
        tick();
        rst = 1'b1;
        tick();
        #1;
        check("rst_ready", ready, 1);
        check("rst_valid", valid_out, 0);
        check("rst_delay", delay_out, 4);
        check("rst_busy", busy, 0);
        check("rst_err", cfg_err, 0);
        check("rst_q", q, 0);

        // Back-to-back stream at delay 4
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c < 5) begin
                valid = 1'b1;
                d = 8'(8'h11 + c);
            end
            #1;
            check("s1_v", valid_out, (c >= 4 && c <= 8));
            if (c >= 4 && c <= 8) check("s1_q", q, 8'h11 + c - 4);
        end

        // Stall for 3 cycles while words are in flight
        for (int c = 0; c < 14; c++) begin
            tick();
            en = !(c >= 3 && c <= 5);
            if (c < 3 || c == 6 || c == 7) begin
                valid = 1'b1;
                d = 8'(8'h11 + (c < 3 ? c : c - 3));
            end
            #1;
            check("s2_v", valid_out, (c >= 7 && c <= 11));
            if (c >= 7 && c <= 11) check("s2_q", q, 8'h11 + c - 7);
        end

        // Retap 4 -> 2 with 3 words in flight
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c < 3) begin
                valid = 1'b1;
                d = 8'(8'h21 + c);
            end
            if (c == 2) begin
                ld = 1'b1;
                dly = 5'd2;
            end
            if (c == 4) begin
                valid = 1'b1;
                d = 8'hee;
            end
            if (c == 8) begin
                valid = 1'b1;
                d = 8'h55;
            end
            #1;
            check("rt_busy", busy, (c >= 3 && c <= 7));
            check("rt_ready", ready, !(c >= 3 && c <= 7));
            check("rt_delay", delay_out, (c <= 7) ? 4 : 2);
            check("rt_v", valid_out, (c >= 4 && c <= 6) || c == 10);
            if (c >= 4 && c <= 6) check("rt_q", q, 8'h21 + c - 4);
            if (c == 10) check("rt_q2", q, 8'h55);
        end

        // Retap to 0 from empty: one DRAIN cycle then passthrough
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) ld = 1'b1;
            if (c == 2) begin
                valid = 1'b1;
                d = 8'h77;
            end
            if (c == 3) begin
                valid = 1'b1;
                d = 8'h78;
            end
            #1;
            check("z_busy", busy, c == 1);
            if (c >= 2) check("z_delay", delay_out, 0);
            check("z_v", valid_out, (c == 2 || c == 3));
            if (c == 2) check("z_q", q, 8'h77);
            if (c == 3) check("z_q", q, 8'h78);
        end

        // Back to delay 4, then flush 4 in-flight words
        for (int c = 0; c < 13; c++) begin
            tick();
            if (c == 0) begin
                ld = 1'b1;
                dly = 5'd4;
            end
            if (c >= 3 && c <= 6) begin
                valid = 1'b1;
                d = 8'(8'h31 + c - 3);
            end
            if (c == 7) flush = 1'b1;
            #1;
            if (c == 1) check("f_busy1", busy, 1);
            if (c == 2) check("f_delay", delay_out, 4);
            check("f_v", valid_out, c == 7);
            if (c == 7) check("f_q", q, 8'h31);
        end

        // Same-delay reload after flush drains in a single cycle
        for (int c = 0; c < 3; c++) begin
            tick();
            if (c == 0) begin
                ld = 1'b1;
                dly = 5'd4;
            end
            #1;
            check("sd_busy", busy, c == 1);
            check("sd_delay", delay_out, 4);
        end

        // Flush during DRAIN lets the retap complete
        for (int c = 0; c < 9; c++) begin
            tick();
            if (c == 0 || c == 1) begin
                valid = 1'b1;
                d = 8'(8'h41 + c);
            end
            if (c == 1) begin
                ld = 1'b1;
                dly = 5'd3;
            end
            if (c == 2) flush = 1'b1;
            #1;
            if (c == 2) check("fd_busy", busy, 1);
            if (c >= 4) check("fd_busy2", busy, 0);
            if (c >= 4) check("fd_delay", delay_out, 3);
            check("fd_v", valid_out, 0);
        end

        // Out-of-range request clamps to 16 and pulses cfg_err once
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 0) begin
                ld = 1'b1;
                dly = 5'd20;
            end
            #1;
            check("cl_err", cfg_err, c == 1);
            check("cl_busy", busy, c == 1);
            if (c >= 2) check("cl_delay", delay_out, 16);
        end

        // Reset mid-DRAIN abandons the pending delay
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c == 0) begin
                valid = 1'b1;
                d = 8'h99;
            end
            if (c == 1) begin
                ld = 1'b1;
                dly = 5'd5;
            end
            if (c == 3) rst = 1'b1;
            #1;
            if (c == 2) check("rd_busy", busy, 1);
            if (c >= 4) begin
                check("rd_busy2", busy, 0);
                check("rd_delay", delay_out, 4);
                check("rd_ready", ready, 1);
                check("rd_v", valid_out, 0);
            end
            if (c == 4) check("rd_q", q, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
